nb_pos_write_dispatch: RTL and testbench

// - Receives remote particle-position packets tagged with source global cell ID (x,y,z) from the inter-FPGA receive path.
// - Maps each packet to one of the 27 local neighbour-cell slots, using three compute_nb_cid_1d instances.
// - Assigns a per-slot write address and issues a write to the neighbour position cache.
// - Tracks end-of-cell markers to signal when all expected source cells have arrived for the timestep.

---
 rtl/MD_pkg.sv | 37 +++
 rtl/compute_nb_cid_1d.sv | 30 +++
 rtl/nb_pos_write_dispatch.sv | 192 +++++++++++++++++++
 tb/tb_nb_pos_write_dispatch.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/MD_pkg.sv
// Shared types for the neighbour-position write path: slot geometry,
// per-dimension neighbour codes and the received position packet.
package MD_pkg;

    localparam int NUM_NB_CELLS         = 27;
    localparam int NB_IDX_WIDTH         = 5;
    localparam int GLOBAL_CELL_ID_WIDTH = 3;
    localparam int POS_DATA_WIDTH       = 96;

    typedef enum logic [1:0] {
        NB_MINUS = 2'b01,
        NB_HOME  = 2'b10,
        NB_PLUS  = 2'b11
    } nb_code_t;

    typedef struct packed {
        logic [GLOBAL_CELL_ID_WIDTH-1:0] x;
        logic [GLOBAL_CELL_ID_WIDTH-1:0] y;
        logic [GLOBAL_CELL_ID_WIDTH-1:0] z;
        logic [POS_DATA_WIDTH-1:0]       data;
        logic                            last;
    } pos_pkt_t;

    // Codes run 1..3, so code-1 is the 0..2 offset in each dimension.
    function automatic logic [NB_IDX_WIDTH-1:0] nb_flat_idx(input nb_code_t cx,
                                                            input nb_code_t cy,
                                                            input nb_code_t cz);
        int ix;
        int iy;
        int iz;
        ix = int'(cx) - 1;
        iy = int'(cy) - 1;
        iz = int'(cz) - 1;
        return NB_IDX_WIDTH'(ix * 9 + iy * 3 + iz);
    endfunction

endpackage

// File: rtl/compute_nb_cid_1d.sv
// One-dimension neighbour code of a source cell relative to home, with
// periodic wrap. Non-neighbours fall into NB_PLUS; callers range-check.
module compute_nb_cid_1d
    import MD_pkg::*;
#(
    parameter int DIM = 4
) (
    input  logic [GLOBAL_CELL_ID_WIDTH-1:0] home_i,
    input  logic [GLOBAL_CELL_ID_WIDTH-1:0] src_i,
    output nb_code_t                        code_o
);

    localparam int            GW      = GLOBAL_CELL_ID_WIDTH;
    localparam logic [GW-1:0] LAST_ID = GW'(DIM - 1);

    logic [GW-1:0] minus_id;

    assign minus_id = (home_i == '0) ? LAST_ID : home_i - GW'(1);

    always_comb begin
        if (src_i == home_i) begin
            code_o = NB_HOME;
        end else if (src_i == minus_id) begin
            code_o = NB_MINUS;
        end else begin
            code_o = NB_PLUS;
        end
    end

endmodule

// File: rtl/nb_pos_write_dispatch.sv
// Maps remote position packets onto the 27 neighbour slots, hands out
// per-slot write addresses and tracks end-of-cell markers per timestep.
module nb_pos_write_dispatch
    import MD_pkg::*;
#(
    parameter int HOME_X        = 1,
    parameter int HOME_Y        = 1,
    parameter int HOME_Z        = 1,
    parameter int DIM_X         = 4,
    parameter int DIM_Y         = 4,
    parameter int DIM_Z         = 4,
    parameter int DATA_WIDTH    = POS_DATA_WIDTH,
    parameter int CELL_CAPACITY = 64,
    parameter int ADDR_WIDTH    = $clog2(CELL_CAPACITY) + 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_start,
    input  logic [4:0]                      i_num_src_cells,
    input  logic                            i_valid,
    output logic                            o_ready,
    input  logic [GLOBAL_CELL_ID_WIDTH-1:0] i_src_gcid_x,
    input  logic [GLOBAL_CELL_ID_WIDTH-1:0] i_src_gcid_y,
    input  logic [GLOBAL_CELL_ID_WIDTH-1:0] i_src_gcid_z,
    input  logic [DATA_WIDTH-1:0]           i_data,
    input  logic                            i_last,
    output logic                            o_wr_en,
    output logic [NB_IDX_WIDTH-1:0]         o_wr_nb_idx,
    output logic [ADDR_WIDTH-1:0]           o_wr_addr,
    output logic [DATA_WIDTH-1:0]           o_wr_data,
    output logic                            o_done,
    output logic                            o_overflow,
    output logic [7:0]                      o_err_cnt,
    input  logic [NB_IDX_WIDTH-1:0]         i_rd_idx,
    output logic [ADDR_WIDTH-1:0]           o_rd_count
);

    localparam int                    GW      = GLOBAL_CELL_ID_WIDTH;
    localparam logic [GW-1:0]         HOME_XG = GW'(HOME_X);
    localparam logic [GW-1:0]         HOME_YG = GW'(HOME_Y);
    localparam logic [GW-1:0]         HOME_ZG = GW'(HOME_Z);
    localparam logic [ADDR_WIDTH-1:0] CAP_CNT = ADDR_WIDTH'(CELL_CAPACITY);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic nb_in_range(input logic [GW-1:0] src,
                                         input int home, input int dim);
        int s;
        s = int'(src);
        return (s == home) || (s == (home + dim - 1) % dim) || (s == (home + 1) % dim);
    endfunction

    state_t                   state_q, state_d;
    logic                     s1_vld_q;
    pos_pkt_t                 s1_pkt_q, in_pkt;
    logic [ADDR_WIDTH-1:0]    cnt_q [NUM_NB_CELLS];
    logic [ADDR_WIDTH-1:0]    cnt_d [NUM_NB_CELLS];
    logic [4:0]               last_cnt_q, last_cnt_d;
    logic                     wr_en_q, wr_en_d;
    logic [NB_IDX_WIDTH-1:0]  wr_idx_q, wr_idx_d;
    logic [ADDR_WIDTH-1:0]    wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;
    logic                     done_q, done_d;
    logic                     overflow_q, overflow_d;
    logic [7:0]               err_cnt_q, err_cnt_d;

    nb_code_t                 code_x, code_y, code_z;
    logic                     in_range;
    logic [NB_IDX_WIDTH-1:0]  slot;
    logic [ADDR_WIDTH-1:0]    cur_cnt;
    logic                     accept;

    assign o_ready = (state_q == ST_RECV) && !i_start;
    assign accept  = i_valid && o_ready;

    always_comb begin
        in_pkt      = '0;
        in_pkt.x    = i_src_gcid_x;
        in_pkt.y    = i_src_gcid_y;
        in_pkt.z    = i_src_gcid_z;
        in_pkt.data = i_data;
        in_pkt.last = i_last;
    end

    compute_nb_cid_1d #(.DIM(DIM_X)) u_cid_x (.home_i(HOME_XG), .src_i(s1_pkt_q.x), .code_o(code_x));
    compute_nb_cid_1d #(.DIM(DIM_Y)) u_cid_y (.home_i(HOME_YG), .src_i(s1_pkt_q.y), .code_o(code_y));
    compute_nb_cid_1d #(.DIM(DIM_Z)) u_cid_z (.home_i(HOME_ZG), .src_i(s1_pkt_q.z), .code_o(code_z));

    assign in_range = nb_in_range(s1_pkt_q.x, HOME_X, DIM_X) &&
                      nb_in_range(s1_pkt_q.y, HOME_Y, DIM_Y) &&
                      nb_in_range(s1_pkt_q.z, HOME_Z, DIM_Z);
    assign slot     = nb_flat_idx(code_x, code_y, code_z);
    assign cur_cnt  = cnt_q[slot];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_cnt_d = last_cnt_q;
        wr_en_d    = 1'b0;
        wr_idx_d   = wr_idx_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        done_d     = 1'b0;
        overflow_d = overflow_q;
        err_cnt_d  = err_cnt_q;

        // S2: markers count even when the packet itself is dropped.
        if (s1_vld_q) begin
            if (s1_pkt_q.last) begin
                if (last_cnt_q != '1) begin
                    last_cnt_d = last_cnt_q + 5'd1;
                end
                if (state_q == ST_RECV && last_cnt_d == i_num_src_cells) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            if (!in_range) begin
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
            end else if (cur_cnt == CAP_CNT) begin
                overflow_d = 1'b1;
            end else begin
                wr_en_d     = 1'b1;
                wr_idx_d    = slot;
                wr_addr_d   = cur_cnt;
                wr_data_d   = s1_pkt_q.data;
                cnt_d[slot] = cur_cnt + ADDR_WIDTH'(1);
            end
        end

        // A new timestep wins over anything S2 produced this cycle.
        if (i_start) begin
            for (int i = 0; i < NUM_NB_CELLS; i++) begin
                cnt_d[i] = '0;
            end
            last_cnt_d = '0;
            overflow_d = 1'b0;
            err_cnt_d  = '0;
            wr_en_d    = 1'b0;
            done_d     = 1'b0;
            state_d    = ST_RECV;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            s1_vld_q   <= 1'b0;
            s1_pkt_q   <= '0;
            cnt_q      <= '{default: '0};
            last_cnt_q <= '0;
            wr_en_q    <= 1'b0;
            wr_idx_q   <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            s1_vld_q   <= accept;
            if (accept) begin
                s1_pkt_q <= in_pkt;
            end
            cnt_q      <= cnt_d;
            last_cnt_q <= last_cnt_d;
            wr_en_q    <= wr_en_d;
            wr_idx_q   <= wr_idx_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign o_wr_en     = wr_en_q;
    assign o_wr_nb_idx = wr_idx_q;
    assign o_wr_addr   = wr_addr_q;
    assign o_wr_data   = wr_data_q;
    assign o_done      = done_q;
    assign o_overflow  = overflow_q;
    assign o_err_cnt   = err_cnt_q;
    assign o_rd_count  = (i_rd_idx < NB_IDX_WIDTH'(NUM_NB_CELLS)) ? cnt_q[i_rd_idx] : '0;

endmodule

// File: tb/tb_nb_pos_write_dispatch.sv
// Two instances (home 1,1,1 cap 64; home 0,1,3 cap 4) share one stimulus
// stream and are checked cycle by cycle against a slot/counter model.
module tb_nb_pos_write_dispatch;
    import MD_pkg::*;

    localparam int GW = GLOBAL_CELL_ID_WIDTH;
    localparam int DW = POS_DATA_WIDTH;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          i_start, i_valid, i_last;
    logic [4:0]    i_num_src_cells, i_rd_idx;
    logic [GW-1:0] sx, sy, sz;
    logic [DW-1:0] i_data;

    logic          a_ready, a_wr_en, a_done, a_ovf;
    logic [4:0]    a_idx;
    logic [6:0]    a_addr, a_rdc;
    logic [DW-1:0] a_data;
    logic [7:0]    a_err;
    logic          b_ready, b_wr_en, b_done, b_ovf;
    logic [4:0]    b_idx;
    logic [2:0]    b_addr, b_rdc;
    logic [DW-1:0] b_data;
    logic [7:0]    b_err;

    nb_pos_write_dispatch dut_a (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_num_src_cells(i_num_src_cells),
        .i_valid(i_valid), .o_ready(a_ready), .i_src_gcid_x(sx), .i_src_gcid_y(sy),
        .i_src_gcid_z(sz), .i_data(i_data), .i_last(i_last), .o_wr_en(a_wr_en),
        .o_wr_nb_idx(a_idx), .o_wr_addr(a_addr), .o_wr_data(a_data), .o_done(a_done),
        .o_overflow(a_ovf), .o_err_cnt(a_err), .i_rd_idx(i_rd_idx), .o_rd_count(a_rdc));

    nb_pos_write_dispatch #(.HOME_X(0), .HOME_Y(1), .HOME_Z(3), .CELL_CAPACITY(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_num_src_cells(i_num_src_cells),
        .i_valid(i_valid), .o_ready(b_ready), .i_src_gcid_x(sx), .i_src_gcid_y(sy),
        .i_src_gcid_z(sz), .i_data(i_data), .i_last(i_last), .o_wr_en(b_wr_en),
        .o_wr_nb_idx(b_idx), .o_wr_addr(b_addr), .o_wr_data(b_data), .o_done(b_done),
        .o_overflow(b_ovf), .o_err_cnt(b_err), .i_rd_idx(i_rd_idx), .o_rd_count(b_rdc));

    // Reference model: slot counters, error/overflow state and a schedule of
    // expected outputs indexed by cycle (writes appear two cycles after accept).
    int            home [2][3];
    int            cap  [2];
    int            cnt  [2][27];
    int            err  [2];
    bit            ovf  [2];
    int            lastc, nsrc;
    bit            fired, recv;
    bit            e_en   [2][4];
    int            e_idx  [2][4];
    int            e_addr [2][4];
    logic [DW-1:0] e_data [4];
    bit            e_done [4];
    int            cyc;
    int            tests, fails;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offset 0/1/2 = minus/home/plus in a 4-cell periodic dimension, -1 = not a neighbour.
    function automatic int nb_off(input int h, input int s);
        if (s == h) return 1;
        if (s == (h + 3) % 4) return 0;
        if (s == (h + 1) % 4) return 2;
        return -1;
    endfunction

    task automatic model_clear();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 27; i++) cnt[m][i] = 0;
            err[m] = 0;
            ovf[m] = 1'b0;
        end
        lastc = 0;
        fired = 1'b0;
    endtask

    task automatic clear_sched();
        for (int k = 0; k < 4; k++) begin
            e_en[0][k] = 1'b0; e_en[1][k] = 1'b0; e_done[k] = 1'b0;
        end
    endtask

    task automatic step(input bit st, input bit v, input int x, input int y, input int z, input bit l);
        int k, n, ox, oy, oz, slot;
        logic [DW-1:0] d;
        @(negedge clk);
        k = cyc % 4;
        chk("a_wr_en", a_wr_en, e_en[0][k]);
        if (e_en[0][k]) begin
            chk("a_idx", a_idx, e_idx[0][k]);
            chk("a_addr", a_addr, e_addr[0][k]);
            chk("a_data", a_data, e_data[k]);
        end
        chk("b_wr_en", b_wr_en, e_en[1][k]);
        if (e_en[1][k]) begin
            chk("b_idx", b_idx, e_idx[1][k]);
            chk("b_addr", b_addr, e_addr[1][k]);
            chk("b_data", b_data, e_data[k]);
        end
        chk("a_done", a_done, e_done[k]);
        chk("b_done", b_done, e_done[k]);
        if (e_done[k]) recv = 1'b0;
        e_en[0][k] = 1'b0; e_en[1][k] = 1'b0; e_done[k] = 1'b0;

        d = {$urandom, $urandom, $urandom};
        i_start = st; i_valid = v; i_last = l; i_data = d;
        sx = GW'(x); sy = GW'(y); sz = GW'(z);
        #1;
        chk("a_ready", a_ready, recv && !st);
        chk("b_ready", b_ready, recv && !st);

        n = (cyc + 2) % 4;
        if (st) begin
            clear_sched();
            model_clear();
            recv = 1'b1;
        end else if (v && recv) begin
            e_data[n] = d;
            if (l) begin
                lastc++;
                if (!fired && lastc == nsrc) begin
                    fired = 1'b1;
                    e_done[n] = 1'b1;
                end
            end
            for (int m = 0; m < 2; m++) begin
                ox = nb_off(home[m][0], x);
                oy = nb_off(home[m][1], y);
                oz = nb_off(home[m][2], z);
                if (ox < 0 || oy < 0 || oz < 0) begin
                    if (err[m] < 255) err[m]++;
                end else begin
                    slot = ox * 9 + oy * 3 + oz;
                    if (cnt[m][slot] == cap[m]) begin
                        ovf[m] = 1'b1;
                    end else begin
                        e_en[m][n]   = 1'b1;
                        e_idx[m][n]  = slot;
                        e_addr[m][n] = cnt[m][slot];
                        cnt[m][slot]++;
                    end
                end
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 0, 1'b0);
    endtask

    // Only called after idle cycles, so the counters are stable while scanning.
    task automatic check_counts();
        for (int i = 0; i < 27; i++) begin
            i_rd_idx = 5'(i);
            #1;
            chk("a_rd_count", a_rdc, cnt[0][i]);
            chk("b_rd_count", b_rdc, cnt[1][i]);
        end
        chk("a_err_cnt", a_err, err[0]);
        chk("b_err_cnt", b_err, err[1]);
        chk("a_overflow", a_ovf, ovf[0]);
        chk("b_overflow", b_ovf, ovf[1]);
    endtask

    task automatic check_reset_outputs();
        chk("rst_wr_en", {a_wr_en, b_wr_en}, 2'b00);
        chk("rst_done", {a_done, b_done}, 2'b00);
        chk("rst_ready", {a_ready, b_ready}, 2'b00);
        chk("rst_ovf", {a_ovf, b_ovf}, 2'b00);
        chk("rst_err", {a_err, b_err}, 16'h0);
        chk("rst_addr", {a_idx, a_addr, b_idx, b_addr}, 20'h0);
        chk("rst_data", a_data | b_data, 96'h0);
        i_rd_idx = 5'd13;
        #1;
        chk("rst_rd_count", {a_rdc, b_rdc}, 10'h0);
    endtask

    initial begin
        home[0] = '{1, 1, 1}; home[1] = '{0, 1, 3};
        cap[0] = 64; cap[1] = 4;
        tests = 0; fails = 0; cyc = 0; recv = 1'b0;
        model_clear();
        clear_sched();
        rst_n = 1'b0; i_start = 1'b0; i_valid = 1'b0; i_last = 1'b0;
        i_data = '0; sx = '0; sy = '0; sz = '0; i_rd_idx = '0;
        nsrc = 27; i_num_src_cells = 5'(nsrc);
        #12;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Offers while IDLE are not taken.
        step(1'b0, 1'b1, 1, 1, 1, 1'b0);
        step(1'b0, 1'b1, 1, 1, 1, 1'b0);
        idle(2);
        check_counts();

        // Home cell back-to-back: slot 13 in A, addresses 0,1,2.
        step(1'b1, 1'b0, 0, 0, 0, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1, 1, 1, 1'b0);
        idle(3);
        check_counts();
        i_rd_idx = 5'd13;
        #1;
        chk("home_slot_count", a_rdc, 7'd3);

        // Wrapped minus-x source: dropped by A, slot 4 in B.
        step(1'b1, 1'b0, 0, 0, 0, 1'b0);
        step(1'b0, 1'b1, 3, 1, 3, 1'b0);
        idle(3);
        check_counts();

        // Capacity: 66 packets at (2,2,2); A fills slot 26 and drops two.
        step(1'b1, 1'b0, 0, 0, 0, 1'b0);
        repeat (66) step(1'b0, 1'b1, 2, 2, 2, 1'b0);
        idle(3);
        check_counts();
        chk("a_ovf_set", a_ovf, 1'b1);

        // Non-neighbour flood saturates the error counter.
        step(1'b1, 1'b0, 0, 0, 0, 1'b0);
        repeat (260) step(1'b0, 1'b1, 3, 3, 0, 1'b0);
        idle(3);
        check_counts();
        chk("err_saturated", a_err, 8'd255);

        // Two end-of-cell markers finish the timestep; DONE refuses packets.
        nsrc = 2; i_num_src_cells = 5'(nsrc);
        step(1'b1, 1'b0, 0, 0, 0, 1'b0);
        step(1'b0, 1'b1, 0, 1, 1, 1'b1);
        step(1'b0, 1'b1, 1, 1, 1, 1'b1);
        step(1'b0, 1'b0, 0, 0, 0, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1, 1, 1, 1'b0);
        idle(2);
        check_counts();
        step(1'b1, 1'b0, 0, 0, 0, 1'b0);
        idle(2);
        check_counts();

        // Randomized timesteps, including restarts mid-stream.
        for (int seg = 0; seg < 6; seg++) begin
            nsrc = int'($urandom_range(3, 6));
            i_num_src_cells = 5'(nsrc);
            step(1'b1, 1'b0, 0, 0, 0, 1'b0);
            for (int i = 0; i < 120; i++) begin
                step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0));
            end
            idle(3);
            check_counts();
        end

        // Reset in the middle of a burst.
        nsrc = 27; i_num_src_cells = 5'(nsrc);
        step(1'b1, 1'b0, 0, 0, 0, 1'b0);
        repeat (5) step(1'b0, 1'b1, 1, 2, 0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        model_clear();
        clear_sched();
        recv = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step(1'b0, 1'b1, 1, 1, 1, 1'b0);
        idle(2);
        check_counts();
        step(1'b1, 1'b0, 0, 0, 0, 1'b0);
        repeat (2) step(1'b0, 1'b1, 1, 1, 1, 1'b0);
        idle(3);
        check_counts();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
